// File: rtl/ssd_scan_ctrl.sv
// Two-digit seven-segment scan controller: refresh-driven digit select, anti-ghost
// blanking at each switch, leading-digit suppression and a two-digit key entry buffer.
module ssd_scan_ctrl #(
  parameter int clk_freq     = 125_000_000,
  parameter int refresh_hz   = 100,
  parameter int blank_cycles = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       clr,
  output logic [3:0] digit_val,
  output logic       chip_sel,
  output logic       blank,
  output logic [3:0] left_digit,
  output logic [3:0] right_digit,
  output logic [1:0] entry_count
);

  localparam int DWELL = clk_freq / (2 * refresh_hz);
  localparam int CW    = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0] BLANK_END  = CW'(blank_cycles);

  generate
    if (blank_cycles < 1 || blank_cycles >= DWELL) begin : g_bad_blank
      $fatal(1, "ssd_scan_ctrl: blank_cycles must satisfy 1 <= blank_cycles < DWELL");
    end
  endgenerate

  typedef enum logic {SHOW_R = 1'b0, SHOW_L = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    left_q, left_d;
  logic [3:0]    right_q, right_d;
  logic [1:0]    count_q, count_d;
  logic [3:0]    dig_q, dig_d;
  logic          blank_q, blank_d;

  // Outputs are derived from next-state values so every registered output
  // stays consistent with the registered counter, state and buffer.
  always_comb begin
    cnt_d   = cnt_q + 1'b1;
    state_d = state_q;
    if (cnt_q == DWELL_LAST) begin
      cnt_d   = '0;
      state_d = (state_q == SHOW_R) ? SHOW_L : SHOW_R;
    end

    left_d  = left_q;
    right_d = right_q;
    count_d = count_q;
    if (clr) begin
      left_d  = 4'h0;
      right_d = 4'h0;
      count_d = 2'd0;
    end else if (key_valid) begin
      left_d  = right_q;
      right_d = key_code;
      count_d = (count_q == 2'd2) ? 2'd2 : count_q + 2'd1;
    end

    dig_d   = (state_d == SHOW_L) ? left_d : right_d;
    blank_d = (cnt_d < BLANK_END) || (count_d == 2'd0) ||
              ((count_d == 2'd1) && (state_d == SHOW_L));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= SHOW_R;
      cnt_q   <= '0;
      left_q  <= 4'h0;
      right_q <= 4'h0;
      count_q <= 2'd0;
      dig_q   <= 4'h0;
      blank_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      left_q  <= left_d;
      right_q <= right_d;
      count_q <= count_d;
      dig_q   <= dig_d;
      blank_q <= blank_d;
    end
  end

  assign chip_sel    = (state_q == SHOW_L);
  assign digit_val   = dig_q;
  assign blank       = blank_q;
  assign left_digit  = left_q;
  assign right_digit = right_q;
  assign entry_count = count_q;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Bench for ssd_scan_ctrl: directed scenarios plus random key/clear/reset traffic,
// compared every cycle against a time-since-reset model of scan and entry buffer.
module tb_ssd_scan_ctrl;

  localparam int DWELL = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'h0;
  logic       clr = 1'b0;
  logic [3:0] digit_val;
  logic       chip_sel;
  logic       blank;
  logic [3:0] left_digit;
  logic [3:0] right_digit;
  logic [1:0] entry_count;

  int errors = 0;
  int checks = 0;

  // Reference model: cycles since reset plus a digit history
  int         t_m = 0;
  logic [3:0] hist_m[$];
  int         cnt_m = 0;

  ssd_scan_ctrl #(
    .clk_freq    (1000),
    .refresh_hz  (50),
    .blank_cycles(2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .clr        (clr),
    .digit_val  (digit_val),
    .chip_sel   (chip_sel),
    .blank      (blank),
    .left_digit (left_digit),
    .right_digit(right_digit),
    .entry_count(entry_count)
  );

  always #5 clk = ~clk;

  function automatic void model_clear();
    hist_m.delete();
    hist_m.push_back(4'h0);
    hist_m.push_back(4'h0);
    cnt_m = 0;
  endfunction

  function automatic void model_edge(input logic r, input logic kv, input logic [3:0] kc,
                                     input logic c);
    if (!r) begin
      t_m = 0;
      model_clear();
    end else begin
      t_m++;
      if (c) model_clear();
      else if (kv) begin
        hist_m.push_back(kc);
        void'(hist_m.pop_front());
        if (cnt_m < 2) cnt_m++;
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0d observed=%h expected=%h", tag, t_m, obs, exp);
    end
  endtask

  task automatic check_all();
    logic       sel_e;
    int         phase;
    logic       blk_e;
    logic [3:0] dig_e;
    sel_e = ((t_m / DWELL) % 2) == 1;
    phase = t_m % DWELL;
    blk_e = (phase < 2) || (cnt_m == 0) || (cnt_m == 1 && sel_e);
    dig_e = sel_e ? hist_m[0] : hist_m[1];
    chk("chip_sel", {3'b0, chip_sel}, {3'b0, sel_e});
    chk("blank", {3'b0, blank}, {3'b0, blk_e});
    chk("digit_val", digit_val, dig_e);
    chk("left_digit", left_digit, hist_m[0]);
    chk("right_digit", right_digit, hist_m[1]);
    chk("entry_count", {2'b0, entry_count}, 4'(cnt_m));
  endtask

  task automatic step(input logic r, input logic kv, input logic [3:0] kc, input logic c);
    rst_n = r; key_valid = kv; key_code = kc; clr = c;
    @(posedge clk);
    model_edge(r, kv, kc, c);
    @(negedge clk);
    rst_n = 1'b1; key_valid = 1'b0; clr = 1'b0;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 4'h0, 1'b0);
  endtask

  initial begin
    int guard;
    model_clear();
    @(negedge clk);

    // Reset and idle scan with everything suppressed
    step(1'b0, 1'b0, 4'h0, 1'b0);
    idle(40);

    // Single key: right digit shown, left suppressed
    step(1'b1, 1'b1, 4'h7, 1'b0);
    idle(25);

    // Three back-to-back keys
    step(1'b1, 1'b1, 4'h3, 1'b0);
    step(1'b1, 1'b1, 4'hA, 1'b0);
    step(1'b1, 1'b1, 4'hF, 1'b0);
    idle(25);

    // clr wins over a coincident key
    step(1'b1, 1'b1, 4'h5, 1'b1);
    idle(22);

    // Reset at counter 6 of SHOW_L with two digits buffered
    step(1'b1, 1'b1, 4'h1, 1'b0);
    step(1'b1, 1'b1, 4'h2, 1'b0);
    guard = 0;
    while (!(((t_m / DWELL) % 2) == 1 && (t_m % DWELL) == 5) && guard < 40) begin
      idle(1);
      guard++;
    end
    chk("reach_show_l_cnt5", {3'b0, guard < 40}, 4'h1);
    idle(1);
    step(1'b0, 1'b0, 4'h0, 1'b0);
    idle(22);

    // Key mid-dwell of SHOW_R with segments already enabled
    step(1'b1, 1'b1, 4'h4, 1'b0);
    step(1'b1, 1'b1, 4'h6, 1'b0);
    guard = 0;
    while (!(((t_m / DWELL) % 2) == 0 && (t_m % DWELL) == 4) && guard < 40) begin
      idle(1);
      guard++;
    end
    chk("reach_show_r_cnt4", {3'b0, guard < 40}, 4'h1);
    step(1'b1, 1'b1, 4'h9, 1'b0);
    chk("mid_dwell_digit", digit_val, 4'h9);
    idle(15);

    // Random traffic: keys, occasional clears and resets
    for (int i = 0; i < 600; i++) begin
      logic       r, kv, c;
      logic [3:0] kc;
      r  = ($urandom_range(0, 99) != 0);
      kv = ($urandom_range(0, 3) == 0);
      c  = ($urandom_range(0, 29) == 0);
      kc = 4'($urandom_range(0, 15));
      step(r, kv, kc, c);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ssd_scan_ctrl.md
Name: ssd_scan_ctrl

Overview:
- Time-multiplexes two hex digits onto the shared single-digit segment bus of the two-digit seven-segment module.
- Drives chip_sel itself from a free-running refresh schedule instead of a manual button toggle.
- Inserts a blanking gap at every digit switch to prevent ghosting.
- Holds a two-digit entry buffer fed by keypad decoder key events. Output digit_val feeds the existing hex-to-segment decoder; blank gates its segment output.

Parameters:
clk_freq, 125_000_000, input clock frequency in Hz
refresh_hz, 100, full two-digit refresh rate in Hz; dwell per digit DWELL = clk_freq/(2*refresh_hz) cycles (integer division)
blank_cycles, 16, cycles per dwell with segments blanked after each chip_sel change; must satisfy 1 <= blank_cycles < DWELL (elaboration-time check, fatal on violation)

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset, sampled on rising clk edge
key_valid  input  1  single-cycle pulse: new key accepted from keypad decoder
key_code  input  4  hex value of key, valid when key_valid=1
clr  input  1  single-cycle pulse: clear entry buffer
digit_val  output  4  hex value currently presented to segment decoder
chip_sel  output  1  digit select; 0 = right digit, 1 = left digit
blank  output  1  1 = segments must be driven off
left_digit  output  4  buffered left (older) digit
right_digit  output  4  buffered right (newest) digit
entry_count  output  2  number of valid buffered digits, saturates at 2

Behaviour:
- Reset (rst_n=0 at clk edge): state SHOW_R, dwell counter 0, left_digit=0, right_digit=0, entry_count=0, chip_sel=0, digit_val=0, blank=1. Reset overrides all other inputs, including mid-dwell and mid-blank.
- All outputs are registered. Buffer changes appear on outputs the cycle after the input edge.
- Scan FSM has two states, SHOW_R and SHOW_L.
  - Each state lasts exactly DWELL cycles, then moves to the other state; the counter wraps to 0 on the switch.
  - chip_sel = 0 in SHOW_R, 1 in SHOW_L.
  - digit_val = right_digit in SHOW_R, left_digit in SHOW_L.
  - chip_sel and digit_val change on the same edge.
- Blanking:
  - blank=1 for counter values 0..blank_cycles-1 of every dwell, including the first dwell after reset.
  - For the rest of the dwell, blank=0 unless digit suppression applies.
- Leading-digit suppression, applied after the blank window:
  - entry_count=0: blank=1 in both states.
  - entry_count=1: blank=1 in SHOW_L only.
  - entry_count=2: no suppression.
  - The scan keeps running in every case.
- Entry buffer:
  - key_valid=1: left_digit<=right_digit, right_digit<=key_code, entry_count<=min(entry_count+1,2).
  - Back-to-back key_valid pulses on consecutive cycles are each accepted.
- clr=1: left_digit<=0, right_digit<=0, entry_count<=0. When clr and key_valid coincide, clr wins and the key is dropped.
- Buffer updates never disturb scan timing; a new value is shown at the next digit_val update or immediately if that digit is currently displayed.
- Counter width is clog2(DWELL). The counter never exceeds DWELL-1.

Test Plan (clk_freq=1000, refresh_hz=50 -> DWELL=10, blank_cycles=2):
- Reset -> release rst_n, no keys for 40 cycles: chip_sel toggles every 10 cycles starting 0, blank=1 continuously, digit_val=0, entry_count=0.
- Single key_code=0x7 pulse -> right_digit=7, entry_count=1. In SHOW_R, blank=1 for 2 cycles then 0 for 8 with digit_val=7. In SHOW_L, blank=1 for all 10 cycles.
- Keys 0x3, 0xA, 0xF on consecutive cycles -> left_digit=0xA, right_digit=0xF, entry_count=2. Both digits unblanked after their 2-cycle gap, with chip_sel=1 -> digit_val=0xA.
- clr and key_valid (0x5) in the same cycle with entry_count=2 -> both digits 0, entry_count=0, key dropped, blank=1 in both states.
- rst_n low for one cycle at counter=6 of SHOW_L with entry_count=2 -> next cycle state SHOW_R, counter 0, chip_sel=0, buffer cleared, blank=1. Next toggle occurs exactly 10 cycles after release.
- Key 0x9 arrives mid-dwell of SHOW_R with blank=0 -> digit_val becomes 9 one cycle later. chip_sel and the dwell boundary are unshifted.
